// File: rtl/guitar_hero_pkg.sv
// Shared screen geometry, hit-window bounds and palette for the note highway.
package guitar_hero_pkg;

  localparam logic [9:0] H_ACTIVE     = 10'd640;
  localparam logic [9:0] V_ACTIVE     = 10'd480;
  localparam logic [9:0] TICK_X       = 10'd639;
  localparam logic [9:0] TICK_Y       = 10'd479;

  localparam logic [9:0] LANE_X0      = 10'd160;
  localparam logic [9:0] LANE_W       = 10'd80;
  localparam int         NUM_LANES    = 4;
  localparam logic [9:0] NOTE_X_LO    = 10'd8;
  localparam logic [9:0] NOTE_X_HI    = 10'd71;
  localparam logic [9:0] NOTE_H       = 10'd16;

  localparam logic [9:0] HIT_Y_LO     = 10'd424;
  localparam logic [9:0] HIT_Y_HI     = 10'd447;
  localparam logic [9:0] HITLINE_Y_LO = 10'd440;
  localparam logic [9:0] HITLINE_Y_HI = 10'd443;
  localparam logic [9:0] HITLINE_X_HI = 10'd479;

  typedef logic [11:0] rgb_t;

  localparam rgb_t COL_BLACK  = 12'h000;
  localparam rgb_t COL_WHITE  = 12'hFFF;
  localparam rgb_t COL_GREY   = 12'h888;
  localparam rgb_t COL_GREEN  = 12'h0F0;
  localparam rgb_t COL_RED    = 12'hF00;
  localparam rgb_t COL_YELLOW = 12'hFF0;
  localparam rgb_t COL_BLUE   = 12'h00F;

  typedef enum logic [1:0] {
    LANE_GREEN  = 2'd0,
    LANE_RED    = 2'd1,
    LANE_YELLOW = 2'd2,
    LANE_BLUE   = 2'd3
  } lane_t;

  function automatic rgb_t lane_colour(lane_t lane);
    case (lane)
      LANE_GREEN:  return COL_GREEN;
      LANE_RED:    return COL_RED;
      LANE_YELLOW: return COL_YELLOW;
      default:     return COL_BLUE;
    endcase
  endfunction

  function automatic logic [9:0] lane_origin(lane_t lane);
    return LANE_X0 + LANE_W * {8'd0, lane};
  endfunction

  // Dividers sit on the left edge of every lane plus the right edge of the last.
  function automatic logic is_divider(logic [9:0] x);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k <= NUM_LANES; k++) begin
      if (x == LANE_X0 + LANE_W * 10'(k)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/note_slot.sv
// One on-screen note: valid/lane/y state, per-frame fall, and pixel coverage test.
module note_slot
  import guitar_hero_pkg::*;
#(
  parameter int SPEED = 4
) (
  input  logic       VGAclk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  lane_t      load_lane,
  input  logic       clear,
  input  logic [9:0] px,
  input  logic [9:0] py,
  output logic       valid,
  output lane_t      lane,
  output logic [9:0] y,
  output logic       miss,
  output logic       pix_on
);

  logic [10:0] y_next;
  logic [10:0] y_bot;
  logic [9:0]  x_lo;
  logic [9:0]  x_hi;
  logic        falls_off;

  assign y_next    = {1'b0, y} + 11'(SPEED);
  assign falls_off = (y_next >= {1'b0, V_ACTIVE});

  // A note removed by a strum on the tick cycle is not also a miss.
  assign miss = valid && tick && !clear && falls_off;

  assign x_lo   = lane_origin(lane) + NOTE_X_LO;
  assign x_hi   = lane_origin(lane) + NOTE_X_HI;
  assign y_bot  = {1'b0, y} + {1'b0, NOTE_H} - 11'd1;
  assign pix_on = valid && (px >= x_lo) && (px <= x_hi) &&
                  ({1'b0, py} >= {1'b0, y}) && ({1'b0, py} <= y_bot);

  always_ff @(posedge VGAclk) begin
    if (reset) begin
      valid <= 1'b0;
      lane  <= LANE_GREEN;
      y     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      lane  <= load_lane;
      y     <= '0;
    end else if (tick && valid) begin
      if (falls_off) valid <= 1'b0;
      else           y     <= y_next[9:0];
    end
  end

endmodule

// File: rtl/note_highway_renderer.sv
// Note highway: spawn/strum slot selection, miss counting and 1-cycle colour pipeline.
module note_highway_renderer
  import guitar_hero_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int SPEED     = 4
) (
  input  logic       VGAclk,
  input  logic       reset,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic       i_spawn_valid,
  input  logic [1:0] i_spawn_lane,
  output logic       o_spawn_ready,
  input  logic       i_hit_valid,
  input  logic [1:0] i_hit_lane,
  output logic [3:0] o_red,
  output logic [3:0] o_green,
  output logic [3:0] o_blue,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_hit,
  output logic [3:0] o_miss_cnt
);

  logic                 tick;
  logic [NUM_SLOTS-1:0] slot_valid;
  logic [NUM_SLOTS-1:0] slot_miss;
  logic [NUM_SLOTS-1:0] slot_pix;
  logic [NUM_SLOTS-1:0] load_vec;
  logic [NUM_SLOTS-1:0] clear_vec;
  logic [NUM_SLOTS-1:0] hit_sel;
  lane_t                slot_lane [NUM_SLOTS];
  logic [9:0]           slot_y    [NUM_SLOTS];

  logic                 spawn_found;
  logic                 hit_found;
  logic [9:0]           best_y;
  logic                 note_found;
  rgb_t                 note_col;
  rgb_t                 pix_col;
  logic                 active;
  logic [3:0]           miss_sum;

  assign tick          = (i_x == TICK_X) && (i_y == TICK_Y);
  assign o_spawn_ready = ~&slot_valid;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    note_slot #(.SPEED(SPEED)) u_slot (
      .VGAclk    (VGAclk),
      .reset     (reset),
      .tick      (tick),
      .load      (load_vec[g]),
      .load_lane (lane_t'(i_spawn_lane)),
      .clear     (clear_vec[g]),
      .px        (i_x),
      .py        (i_y),
      .valid     (slot_valid[g]),
      .lane      (slot_lane[g]),
      .y         (slot_y[g]),
      .miss      (slot_miss[g]),
      .pix_on    (slot_pix[g])
    );
  end

  // Spawn goes to the lowest-index free slot; selection uses registered valid only.
  always_comb begin
    load_vec    = '0;
    spawn_found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!slot_valid[i] && !spawn_found) begin
        load_vec[i] = i_spawn_valid;
        spawn_found = 1'b1;
      end
    end
  end

  // Deepest in-window note in the strummed lane wins; strict '>' keeps the lowest index on ties.
  always_comb begin
    hit_sel   = '0;
    hit_found = 1'b0;
    best_y    = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_valid[i] && (slot_lane[i] == lane_t'(i_hit_lane)) &&
          (slot_y[i] >= HIT_Y_LO) && (slot_y[i] <= HIT_Y_HI) &&
          (!hit_found || (slot_y[i] > best_y))) begin
        hit_sel    = '0;
        hit_sel[i] = 1'b1;
        best_y     = slot_y[i];
        hit_found  = 1'b1;
      end
    end
    clear_vec = (i_hit_valid && hit_found) ? hit_sel : '0;
  end

  always_comb begin
    miss_sum = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      miss_sum = miss_sum + {3'd0, slot_miss[i]};
    end
  end

  always_comb begin
    note_found = 1'b0;
    note_col   = COL_BLACK;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_pix[i] && !note_found) begin
        note_col   = lane_colour(slot_lane[i]);
        note_found = 1'b1;
      end
    end
  end

  always_comb begin
    active  = (i_x < H_ACTIVE) && (i_y < V_ACTIVE);
    pix_col = COL_BLACK;
    if (!active)
      pix_col = COL_BLACK;
    else if (note_found)
      pix_col = note_col;
    else if ((i_y >= HITLINE_Y_LO) && (i_y <= HITLINE_Y_HI) &&
             (i_x >= LANE_X0) && (i_x <= HITLINE_X_HI))
      pix_col = COL_WHITE;
    else if (is_divider(i_x))
      pix_col = COL_GREY;
  end

  always_ff @(posedge VGAclk) begin
    if (reset) begin
      {o_red, o_green, o_blue} <= COL_BLACK;
      o_hsync    <= 1'b1;
      o_vsync    <= 1'b1;
      o_hit      <= 1'b0;
      o_miss_cnt <= '0;
    end else begin
      {o_red, o_green, o_blue} <= pix_col;
      o_hsync    <= i_hsync;
      o_vsync    <= i_vsync;
      o_hit      <= i_hit_valid && hit_found;
      o_miss_cnt <= miss_sum;
    end
  end

endmodule

// File: tb/tb_note_highway_renderer.sv
// Directed bench for note_highway_renderer: frame ticks are forced by driving (639,479).
module tb_note_highway_renderer;

  logic       VGAclk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] i_x = '0;
  logic [9:0] i_y = '0;
  logic       i_hsync = 1'b1;
  logic       i_vsync = 1'b1;
  logic       i_spawn_valid = 1'b0;
  logic [1:0] i_spawn_lane = '0;
  logic       o_spawn_ready;
  logic       i_hit_valid = 1'b0;
  logic [1:0] i_hit_lane = '0;
  logic [3:0] o_red, o_green, o_blue;
  logic       o_hsync, o_vsync, o_hit;
  logic [3:0] o_miss_cnt;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  note_highway_renderer #(.NUM_SLOTS(8), .SPEED(4)) dut (
    .VGAclk        (VGAclk),
    .reset         (reset),
    .i_x           (i_x),
    .i_y           (i_y),
    .i_hsync       (i_hsync),
    .i_vsync       (i_vsync),
    .i_spawn_valid (i_spawn_valid),
    .i_spawn_lane  (i_spawn_lane),
    .o_spawn_ready (o_spawn_ready),
    .i_hit_valid   (i_hit_valid),
    .i_hit_lane    (i_hit_lane),
    .o_red         (o_red),
    .o_green       (o_green),
    .o_blue        (o_blue),
    .o_hsync       (o_hsync),
    .o_vsync       (o_vsync),
    .o_hit         (o_hit),
    .o_miss_cnt    (o_miss_cnt)
  );

  always #5 VGAclk = ~VGAclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge VGAclk);
    #1;
  endtask

  task automatic do_tick();
    i_x = 10'd639; i_y = 10'd479;
    step();
    i_x = '0; i_y = '0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) do_tick();
  endtask

  task automatic spawn(input logic [1:0] l);
    i_spawn_valid = 1'b1; i_spawn_lane = l;
    step();
    i_spawn_valid = 1'b0;
  endtask

  task automatic strum(input logic [1:0] l, input logic exp_hit, input string tag);
    i_hit_valid = 1'b1; i_hit_lane = l;
    step();
    i_hit_valid = 1'b0;
    chk(tag, {31'd0, o_hit}, {31'd0, exp_hit});
  endtask

  task automatic probe(input logic [9:0] x, input logic [9:0] y, input logic [11:0] exp, input string tag);
    i_x = x; i_y = y;
    step();
    chk(tag, {20'd0, o_red, o_green, o_blue}, {20'd0, exp});
    i_x = '0; i_y = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Reset with stimulus asserted: everything must be ignored.
    i_x = 10'd300; i_y = 10'd200; i_hsync = 1'b0; i_vsync = 1'b0;
    i_spawn_valid = 1'b1; i_hit_valid = 1'b1;
    step();
    chk("rst_colour", {20'd0, o_red, o_green, o_blue}, 32'h000);
    chk("rst_hsync", {31'd0, o_hsync}, 32'd1);
    chk("rst_vsync", {31'd0, o_vsync}, 32'd1);
    chk("rst_hit", {31'd0, o_hit}, 32'd0);
    chk("rst_miss", {28'd0, o_miss_cnt}, 32'd0);
    step();
    i_spawn_valid = 1'b0; i_hit_valid = 1'b0; i_x = '0; i_y = '0;
    reset = 1'b0;
    chk("rst_ready", {31'd0, o_spawn_ready}, 32'd1);

    // Background and sync pass-through
    probe(10'd160, 10'd100, 12'h888, "divider_k0");
    chk("sync_h_pass", {31'd0, o_hsync}, 32'd0);
    chk("sync_v_pass", {31'd0, o_vsync}, 32'd0);
    i_hsync = 1'b1; i_vsync = 1'b1;
    probe(10'd480, 10'd100, 12'h888, "divider_k4");
    chk("sync_h_high", {31'd0, o_hsync}, 32'd1);
    probe(10'd479, 10'd100, 12'h000, "right_of_lanes");
    probe(10'd200, 10'd441, 12'hFFF, "hit_line");
    probe(10'd200, 10'd100, 12'h000, "black_bg");
    probe(10'd700, 10'd441, 12'h000, "blank_x");
    probe(10'd160, 10'd500, 12'h000, "blank_y");

    // Scenario A: lane 1 note falls to y=440
    spawn(2'd1);
    probe(10'd248, 10'd0, 12'hF00, "spawn_pix");
    probe(10'd247, 10'd0, 12'h000, "note_left_edge");
    probe(10'd311, 10'd15, 12'hF00, "note_br_corner");
    probe(10'd248, 10'd16, 12'h000, "note_below");
    ticks(110);
    probe(10'd248, 10'd445, 12'hF00, "y440_render");
    probe(10'd248, 10'd441, 12'hF00, "note_over_line");
    probe(10'd312, 10'd440, 12'hFFF, "line_beside_note");
    strum(2'd2, 1'b0, "strum_wrong_lane");
    strum(2'd1, 1'b1, "strum_hit_a");
    step();
    chk("hit_pulse_one", {31'd0, o_hit}, 32'd0);
    probe(10'd248, 10'd445, 12'h000, "a_removed");

    // Scenario B: largest-y selection and window bounds
    do_reset();
    spawn(2'd0);
    ticks(4);
    spawn(2'd0);
    ticks(107);
    probe(10'd168, 10'd444, 12'h0F0, "b_deep_present");
    strum(2'd0, 1'b1, "strum_deepest");
    probe(10'd168, 10'd444, 12'h000, "b_deep_removed");
    probe(10'd168, 10'd430, 12'h0F0, "b_shallow_kept");
    strum(2'd0, 1'b1, "strum_second");
    probe(10'd168, 10'd430, 12'h000, "b_shallow_removed");
    spawn(2'd2);
    ticks(105);
    strum(2'd2, 1'b0, "window_y420");
    do_tick();
    strum(2'd2, 1'b1, "window_y424");
    spawn(2'd3);
    ticks(112);
    strum(2'd3, 1'b0, "window_y448");
    probe(10'd408, 10'd448, 12'h00F, "blue_y448");

    // Scenario C: three notes fall off on one tick
    do_reset();
    spawn(2'd0);
    spawn(2'd1);
    spawn(2'd2);
    ticks(119);
    chk("miss_before", {28'd0, o_miss_cnt}, 32'd0);
    do_tick();
    chk("miss_three", {28'd0, o_miss_cnt}, 32'd3);
    step();
    chk("miss_cleared", {28'd0, o_miss_cnt}, 32'd0);
    probe(10'd168, 10'd478, 12'h000, "c_gone");
    i_spawn_valid = 1'b1; i_spawn_lane = 2'd3; i_x = 10'd639; i_y = 10'd479;
    step();
    i_spawn_valid = 1'b0; i_x = '0; i_y = '0;
    chk("miss_none_spawn", {28'd0, o_miss_cnt}, 32'd0);
    probe(10'd408, 10'd0, 12'h00F, "spawn_tick_nomove");

    // Scenario D: full slots and strum on a tick cycle
    do_reset();
    spawn(2'd1);
    ticks(111);
    for (int k = 0; k < 7; k++) spawn(2'd0);
    chk("full_ready", {31'd0, o_spawn_ready}, 32'd0);
    spawn(2'd2);
    chk("full_ready_still", {31'd0, o_spawn_ready}, 32'd0);
    probe(10'd328, 10'd0, 12'h000, "ninth_not_loaded");
    i_hit_valid = 1'b1; i_hit_lane = 2'd1; i_x = 10'd639; i_y = 10'd479;
    step();
    i_hit_valid = 1'b0; i_x = '0; i_y = '0;
    chk("tick_hit", {31'd0, o_hit}, 32'd1);
    chk("tick_hit_nomiss", {28'd0, o_miss_cnt}, 32'd0);
    chk("ready_after_hit", {31'd0, o_spawn_ready}, 32'd1);
    probe(10'd248, 10'd450, 12'h000, "tick_hit_not_moved");
    probe(10'd248, 10'd445, 12'h000, "tick_hit_removed");
    probe(10'd168, 10'd4, 12'h0F0, "others_moved");
    probe(10'd168, 10'd3, 12'h000, "others_moved_top");
    spawn(2'd2);
    chk("refill_ready", {31'd0, o_spawn_ready}, 32'd0);
    probe(10'd328, 10'd0, 12'hFF0, "refill_yellow");

    // Scenario E: reset mid-frame at (300,200) with spawn and strum asserted
    i_x = 10'd300; i_y = 10'd200; i_hsync = 1'b0; i_vsync = 1'b0;
    i_spawn_valid = 1'b1; i_spawn_lane = 2'd3; i_hit_valid = 1'b1; i_hit_lane = 2'd0;
    reset = 1'b1;
    step();
    chk("mid_rst_colour", {20'd0, o_red, o_green, o_blue}, 32'h000);
    chk("mid_rst_hsync", {31'd0, o_hsync}, 32'd1);
    chk("mid_rst_vsync", {31'd0, o_vsync}, 32'd1);
    chk("mid_rst_hit", {31'd0, o_hit}, 32'd0);
    reset = 1'b0;
    i_spawn_valid = 1'b0; i_hit_valid = 1'b0; i_x = '0; i_y = '0;
    i_hsync = 1'b1; i_vsync = 1'b1;
    chk("mid_rst_ready", {31'd0, o_spawn_ready}, 32'd1);
    probe(10'd328, 10'd0, 12'h000, "mid_rst_yellow_gone");
    probe(10'd168, 10'd4, 12'h000, "mid_rst_green_gone");
    probe(10'd408, 10'd0, 12'h000, "mid_rst_spawn_ignored");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/note_highway_renderer.md
NOTE_HIGHWAY_RENDERER -- requirements
Module: note_highway_renderer

Interface
REQ-001 The block SHALL have parameter NUM_SLOTS, default 8, giving the number of concurrent on-screen notes.
REQ-002 The block SHALL have parameter SPEED, default 4, giving the pixels a note moves down per frame.
REQ-003 VGAclk  in  1  pixel clock; the single clock for all state.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 i_x, i_y  in  10 each  current pixel coordinate from the VGA timing stage (x 0..799, y 0..524).
REQ-006 i_hsync, i_vsync  in  1 each  sync levels from the timing stage, aligned with i_x/i_y.
REQ-007 i_spawn_valid  in  1; i_spawn_lane  in  2; o_spawn_ready  out  1  note-spawn handshake.
REQ-008 i_hit_valid  in  1; i_hit_lane  in  2  player strum on a lane (single-cycle pulse).
REQ-009 o_red, o_green, o_blue  out  4 each  registered pixel colour.
REQ-010 o_hsync, o_vsync  out  1 each  sync delayed to align with colour.
REQ-011 o_hit  out  1  pulse when a strum removes a note.
REQ-012 o_miss_cnt  out  4  count of notes that fell off-screen on this frame tick; zero otherwise.

Function
REQ-013 Slot state: valid bit, 2-bit lane, 10-bit y (top edge of the note).
REQ-014 Frame tick SHALL be the cycle where i_x==639 and i_y==479.
REQ-015 On a tick, each valid note SHALL compute y+SPEED at 11 bits; if the result >=480 the slot is cleared and counted in o_miss_cnt, otherwise y takes the new value.
REQ-016 o_spawn_ready SHALL be 1 while any slot is invalid, computed from registered state only.
REQ-017 A spawn is accepted when valid&&ready; the lowest-index invalid slot SHALL load lane=i_spawn_lane, y=0, valid=1.
REQ-018 A spawned note SHALL NOT move on the tick of its acceptance cycle.
REQ-019 Hit window: valid note in i_hit_lane with 424<=y<=447. The candidate with the largest y SHALL be cleared; on a tie, the lowest slot index is cleared.
REQ-020 o_hit SHALL pulse one cycle after the accepted hit. A strum with no candidate SHALL have no effect and produce no pulse.
REQ-021 Hit on a tick cycle: the hit SHALL use pre-tick y; the removed note is not moved and is not counted as a miss.
REQ-022 A slot freed in cycle N by a hit or miss SHALL become spawnable in cycle N+1 at the earliest.
REQ-023 Lane geometry: lane L occupies x in [160+80L, 239+80L]; the note rectangle covers x offsets 8..71 and y..y+15.
REQ-024 Colour priority SHALL be note > hit line (y 440..443, x 160..479, white) > lane divider (x = 160+80k for k = 0..4, grey 0x888) > black.
REQ-025 Note colours by lane: 0 green 0x0F0, 1 red 0xF00, 2 yellow 0xFF0, 3 blue 0x00F.
REQ-026 Outside active video (x>=640 or y>=480), colour SHALL be 0x000.
REQ-027 Pipeline latency SHALL be exactly 1 cycle: colour for (x,y) and the delayed syncs appear together on the next edge.
REQ-028 o_miss_cnt SHALL be valid in the cycle after the tick and zero in all other cycles.

Reset
REQ-029 While reset is high, all slots SHALL be cleared and the colour outputs held at 0.
REQ-030 While reset is high, o_hsync and o_vsync SHALL be 1, and o_hit and o_miss_cnt SHALL be 0.
REQ-031 Reset mid-frame SHALL drop all notes, and any spawn or hit asserted in the same cycle SHALL be ignored.

Structure
REQ-032 Shared package guitar_hero_pkg SHALL hold screen extents, lane origin and width, hit-window bounds, hit-line rows, and the colour constants.
REQ-033 One sub-module, note_slot, SHALL be instantiated NUM_SLOTS times. It holds per-slot state, tick update and pixel-hit test; the top level does slot selection and colour priority.

Verification
REQ-034 Spawn lane 1, run 110 ticks -> y=440; pixel (248,445) renders 0xF00 one cycle after it is presented.
REQ-035 Note at y=436, strum lane 1 -> o_hit=1 one cycle later; the slot frees, and o_spawn_ready rises if all slots were full.
REQ-036 Two lane-0 notes at y=428 and y=444, strum lane 0 -> only the y=444 note is removed.
REQ-037 Three notes at y=476 -> on the next tick o_miss_cnt=3 for one cycle, then 0.
REQ-038 Fill 8 slots -> o_spawn_ready=0, and a further spawn is not loaded; a hit in the same cycle as the tick follows REQ-021.
REQ-039 Assert reset at pixel (300,200) -> the next outputs are 0x000 with syncs=1, and all slots are invalid afterwards.
